id_fwd_stage: RTL

Parametrised instruction-decode stage for the 5-stage MIPS pipeline, between the IF/ID boundary and EX. It decodes a 32-bit instruction and resolves both source operands from the register file or from NUM_FWD in-flight writers by internal address matching; no external forwarding selects are used. It detects load-use hazards and resolves branches and jumps in ID. Results go into a registered ID/EX slot with valid/ready handshake, flush, and a wrong-path squash counter.

---
 rtl/id_fwd_stage_pkg.sv | 40 ++++
 rtl/id_fwd_stage_fwd_resolve.sv | 43 ++++
 rtl/id_fwd_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_fwd_stage_pkg.sv
// Shared decode constants, immediate-extension modes and forwarding-bus slice helper
// for the ID stage with internal operand forwarding.
package id_fwd_stage_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [1:0] {
        IMM_SEXT,
        IMM_ZEXT,
        IMM_LUI
    } imm_mode_e;

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } sq_state_e;

    // Low bit of entry idx in a bus packing NUM_FWD entries of the given width.
    function automatic int fwd_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/id_fwd_stage_fwd_resolve.sv
// Priority forwarding match for one source operand: youngest matching writer wins,
// a matching writer whose data is not final raises a hazard.
module id_fwd_stage_fwd_resolve
    import id_fwd_stage_pkg::*;
#(
    parameter int NUM_FWD = 4,
    parameter int DATA_W  = 32
) (
    input  logic [REG_W-1:0]          addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [REG_W*NUM_FWD-1:0]  fwd_addr,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
    output logic [DATA_W-1:0]         value,
    output logic                      hazard
);

    logic matched;

    always_comb begin
        value   = rf_data;
        hazard  = 1'b0;
        matched = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!matched && fwd_valid[i] &&
                (fwd_addr[fwd_lo(i, REG_W) +: REG_W] == addr)) begin
                matched = 1'b1;
                if (fwd_ready[i]) begin
                    value = fwd_data[fwd_lo(i, DATA_W) +: DATA_W];
                end else begin
                    hazard = 1'b1;
                end
            end
        end
        // $zero is hard-wired; writers targeting it never forward or stall.
        if (addr == '0) begin
            value  = '0;
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// Instruction-decode stage: decode, forwarded operand resolution, load-use stall,
// branch/jump resolution and a registered ID/EX slot with wrong-path squashing.
//
// state     | meaning
// ST_RUN    | squash count is zero, instructions may be accepted
// ST_SQUASH | squash count > 0, each in_valid beat is dropped and counted down
module id_fwd_stage
    import id_fwd_stage_pkg::*;
#(
    parameter int NUM_FWD  = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SQUASH_N = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_pc,
    input  logic [31:0]               in_inst,
    output logic [REG_W-1:0]          rf_raddr_a,
    output logic [REG_W-1:0]          rf_raddr_b,
    input  logic [DATA_W-1:0]         rf_rdata_a,
    input  logic [DATA_W-1:0]         rf_rdata_b,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [REG_W*NUM_FWD-1:0]  fwd_addr,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [5:0]                out_opcode,
    output logic [5:0]                out_func,
    output logic [REG_W-1:0]          out_rs,
    output logic [REG_W-1:0]          out_rt,
    output logic [REG_W-1:0]          out_reg_des,
    output logic [DATA_W-1:0]         out_imm,
    output logic [DATA_W-1:0]         out_op_a,
    output logic [DATA_W-1:0]         out_op_b,
    output logic                      redirect_valid,
    output logic [ADDR_W-1:0]         redirect_pc,
    output logic                      hazard_stall
);

    localparam int CNT_W = (SQUASH_N > 0) ? $clog2(SQUASH_N + 1) : 1;

    logic [5:0]       opcode;
    logic [5:0]       func;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [15:0]      imm16;
    logic [25:0]      idx26;

    assign opcode = in_inst[31:26];
    assign rs     = in_inst[25:21];
    assign rt     = in_inst[20:16];
    assign rd     = in_inst[15:11];
    assign imm16  = in_inst[15:0];
    assign func   = in_inst[5:0];
    assign idx26  = in_inst[25:0];

    assign rf_raddr_a = rs;
    assign rf_raddr_b = rt;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              haz_a;
    logic              haz_b;

    id_fwd_stage_fwd_resolve #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_res_a (
        .addr      (rs),
        .rf_data   (rf_rdata_a),
        .fwd_valid (fwd_valid),
        .fwd_ready (fwd_ready),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .value     (op_a),
        .hazard    (haz_a)
    );

    id_fwd_stage_fwd_resolve #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_res_b (
        .addr      (rt),
        .rf_data   (rf_rdata_b),
        .fwd_valid (fwd_valid),
        .fwd_ready (fwd_ready),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .value     (op_b),
        .hazard    (haz_b)
    );

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;

    assign pc_plus4 = in_pc + ADDR_W'(4);
    assign br_tgt   = pc_plus4 + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign jmp_tgt  = {pc_plus4[ADDR_W-1:28], idx26, 2'b00};

    logic              use_a;
    logic              use_b;
    imm_mode_e         imm_mode;
    logic [REG_W-1:0]  reg_des;
    logic              redir;
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] imm_ext;

    always_comb begin
        use_a    = 1'b1;
        use_b    = 1'b0;
        imm_mode = IMM_SEXT;
        reg_des  = rt;
        redir    = 1'b0;
        target   = br_tgt;
        case (opcode)
            OP_RTYPE: begin
                use_b   = 1'b1;
                reg_des = rd;
                if (func == FN_JR) begin
                    redir  = 1'b1;
                    target = ADDR_W'(op_a);
                end
            end
            OP_J, OP_JAL: begin
                use_a   = 1'b0;
                reg_des = (opcode == OP_JAL) ? REG_W'(31) : '0;
                redir   = 1'b1;
                target  = jmp_tgt;
            end
            OP_BEQ: begin
                use_b   = 1'b1;
                reg_des = '0;
                redir   = (op_a == op_b);
            end
            OP_BNE: begin
                use_b   = 1'b1;
                reg_des = '0;
                redir   = (op_a != op_b);
            end
            OP_BLEZ: begin
                reg_des = '0;
                redir   = op_a[DATA_W-1] || (op_a == '0);
            end
            OP_BGTZ: begin
                reg_des = '0;
                redir   = !op_a[DATA_W-1] && (op_a != '0);
            end
            OP_ANDI, OP_ORI, OP_XORI: imm_mode = IMM_ZEXT;
            OP_LUI: begin
                use_a    = 1'b0;
                imm_mode = IMM_LUI;
            end
            OP_SB, OP_SH, OP_SW: begin
                use_b   = 1'b1;
                reg_des = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (imm_mode)
            IMM_ZEXT: imm_ext = {{(DATA_W-16){1'b0}}, imm16};
            IMM_LUI:  imm_ext = {{(DATA_W-16){1'b0}}, imm16} << 16;
            default:  imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
        endcase
    end

    sq_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hazard_any;
    logic accept;
    logic redirect_take;

    assign hazard_any    = (use_a && haz_a) || (use_b && haz_b);
    assign hazard_stall  = in_valid && hazard_any;
    assign in_ready      = (state_q == ST_SQUASH) ||
                           (!hazard_any && (!out_valid || out_ready));
    assign accept        = in_valid && in_ready && !flush && (state_q == ST_RUN);
    assign redirect_take = accept && redir;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_take && (SQUASH_N != 0)) begin
                        state_d = ST_SQUASH;
                        cnt_d   = CNT_W'(SQUASH_N);
                    end
                end
                ST_SQUASH: begin
                    if (in_valid) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_opcode     <= '0;
            out_func       <= '0;
            out_rs         <= '0;
            out_rt         <= '0;
            out_reg_des    <= '0;
            out_imm        <= '0;
            out_op_a       <= '0;
            out_op_b       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_opcode  <= opcode;
                out_func    <= func;
                out_rs      <= rs;
                out_rt      <= rt;
                out_reg_des <= reg_des;
                out_imm     <= imm_ext;
                out_op_a    <= op_a;
                out_op_b    <= op_b;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Pulse is independent of the slot so a stalled EX still sees the redirect.
            redirect_valid <= redirect_take;
            if (redirect_take) redirect_pc <= target;
        end
    end

endmodule
